// File: rtl/axis_packet_generator.sv
// AXI-Stream packet source: runs of framed packets carrying an incrementing data pattern.
// Optional: define AXIS_GEN_ABORT_EN to add an abort input that truncates the run.
module axis_packet_generator #(
    parameter int TDATA_WIDTH = 32,
    parameter int LEN_WIDTH   = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     start,
    input  logic [LEN_WIDTH-1:0]     pkt_len_bytes,
    input  logic [CNT_WIDTH-1:0]     pkt_count,
    input  logic [7:0]               gap_cycles,
    input  logic [TDATA_WIDTH-1:0]   seed,
`ifdef AXIS_GEN_ABORT_EN
    input  logic                     abort,
`endif
    output logic [TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                     m_axis_tvalid,
    output logic                     m_axis_tlast,
    input  logic                     m_axis_tready,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_WIDTH-1:0]     pkts_sent
);

    localparam int BYTES = TDATA_WIDTH / 8;
    localparam int KW    = $clog2(BYTES);

    localparam logic [LEN_WIDTH:0]     ROUND_UP = (LEN_WIDTH+1)'(BYTES - 1);
    localparam logic [LEN_WIDTH-1:0]   LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [TDATA_WIDTH-1:0] DATA_ONE = TDATA_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_GAP,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [7:0]             gap_q, gap_d;
    logic [7:0]             gap_cnt_q, gap_cnt_d;
    logic [TDATA_WIDTH-1:0] data_q, data_d;
    logic [LEN_WIDTH-1:0]   beat_rem_q, beat_rem_d;
    logic [CNT_WIDTH-1:0]   sent_q, sent_d;
    logic                   abort_q, abort_d;

    logic abort_req;
    logic beat_fire;
    logic pkt_end;
    logic tlast_int;

    function automatic logic [LEN_WIDTH-1:0] beats_of(input logic [LEN_WIDTH-1:0] len);
        logic [LEN_WIDTH:0] t;
        t = {1'b0, len} + ROUND_UP;
        return LEN_WIDTH'(t >> KW);
    endfunction

    // Low 'rem' byte lanes set; rem==0 means the final beat is full.
    function automatic logic [BYTES-1:0] tail_keep(input logic [KW-1:0] rem);
        logic [BYTES-1:0] k;
        for (int i = 0; i < BYTES; i++) begin
            k[i] = (rem == '0) || (KW'(i) < rem);
        end
        return k;
    endfunction

`ifdef AXIS_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign m_axis_tvalid = (state_q == S_SEND);
    assign beat_fire     = m_axis_tvalid && m_axis_tready;
    assign pkt_end       = (beat_rem_q == LEN_ONE);
    assign tlast_int     = pkt_end || abort_q;

    assign m_axis_tdata  = data_q;
    assign m_axis_tlast  = m_axis_tvalid && tlast_int;
    assign m_axis_tkeep  = !m_axis_tvalid       ? '0 :
                           (pkt_end && !abort_q) ? tail_keep(len_q[KW-1:0]) : '1;
    assign busy          = (state_q == S_SEND) || (state_q == S_GAP);
    assign done          = (state_q == S_DONE);
    assign pkts_sent     = sent_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            gap_q      <= '0;
            gap_cnt_q  <= '0;
            data_q     <= '0;
            beat_rem_q <= '0;
            sent_q     <= '0;
            abort_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            gap_cnt_q  <= gap_cnt_d;
            data_q     <= data_d;
            beat_rem_q <= beat_rem_d;
            sent_q     <= sent_d;
            abort_q    <= abort_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        gap_d      = gap_q;
        gap_cnt_d  = gap_cnt_q;
        data_d     = data_q;
        beat_rem_d = beat_rem_q;
        sent_d     = sent_q;
        abort_d    = abort_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = pkt_len_bytes;
                    cnt_d      = pkt_count;
                    gap_d      = gap_cycles;
                    data_d     = seed;
                    beat_rem_d = beats_of(pkt_len_bytes);
                    sent_d     = '0;
                    abort_d    = 1'b0;
                    if (pkt_len_bytes == '0 || pkt_count == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_SEND;
                    end
                end
            end
            S_SEND: begin
                // A latched abort turns the next presented beat into the run's last.
                if (abort_req) begin
                    abort_d = 1'b1;
                end
                if (beat_fire) begin
                    data_d = data_q + DATA_ONE;
                    if (tlast_int) begin
                        sent_d     = sent_q + CNT_ONE;
                        beat_rem_d = beats_of(len_q);
                        if (abort_q || (sent_q + CNT_ONE) == cnt_q) begin
                            state_d = S_DONE;
                        end else if (gap_q != 8'd0) begin
                            state_d   = S_GAP;
                            gap_cnt_d = gap_q;
                        end
                    end else begin
                        beat_rem_d = beat_rem_q - LEN_ONE;
                    end
                end
            end
            S_GAP: begin
                if (abort_req) begin
                    state_d = S_DONE;
                end else if (gap_cnt_q <= 8'd1) begin
                    state_d = S_SEND;
                end else begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_packet_generator.sv
// Scoreboard bench for axis_packet_generator: a run-level model queues expected beats,
// a negedge monitor pops and compares on every handshake and watches stalls and gaps.
module tb_axis_packet_generator;

    localparam int W  = 32;
    localparam int B  = W / 8;
    localparam int LW = 16;
    localparam int CW = 16;

    logic          aclk = 1'b0;
    logic          areset;
    logic          start;
    logic [LW-1:0] pkt_len_bytes;
    logic [CW-1:0] pkt_count;
    logic [7:0]    gap_cycles;
    logic [W-1:0]  seed;
    logic [W-1:0]  m_axis_tdata;
    logic [B-1:0]  m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;
    logic          busy;
    logic          done;
    logic [CW-1:0] pkts_sent;
`ifdef AXIS_GEN_ABORT_EN
    logic          abort;
`endif

    axis_packet_generator #(.TDATA_WIDTH(W), .LEN_WIDTH(LW), .CNT_WIDTH(CW)) dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .pkt_len_bytes (pkt_len_bytes),
        .pkt_count     (pkt_count),
        .gap_cycles    (gap_cycles),
        .seed          (seed),
`ifdef AXIS_GEN_ABORT_EN
        .abort         (abort),
`endif
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .busy          (busy),
        .done          (done),
        .pkts_sent     (pkts_sent)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [W-1:0] data;
        logic [B-1:0] keep;
        logic         last;
        int           gap_after;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_hs_cyc = -10;

    // Ready source: 0 = always ready, 1 = random, 2 = manual (man_ready).
    int   ready_mode = 0;
    logic rdy_rand   = 1'b1;
    logic man_ready  = 1'b1;
    bit   skip_last_stab = 1'b0;

    assign m_axis_tready = (ready_mode == 0) ? 1'b1 :
                           (ready_mode == 1) ? rdy_rand : man_ready;

    always @(posedge aclk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            rdy_rand = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // Reference: beat k of the run carries seed+k; packets of ceil(len/B) beats.
    task automatic model_run(input logic [W-1:0] s, input int len, input int cnt, input int gap);
        int           beats;
        int           rem;
        logic [W-1:0] d;
        exp_t         e;
        if (len == 0 || cnt == 0) return;
        beats = (len + B - 1) / B;
        rem   = len % B;
        d     = s;
        for (int p = 0; p < cnt; p++) begin
            for (int b = 0; b < beats; b++) begin
                e.data = d;
                d      = d + 1;
                e.last = (b == beats - 1);
                for (int i = 0; i < B; i++) e.keep[i] = !(e.last && rem != 0) || (i < rem);
                e.gap_after = (e.last && p < cnt - 1) ? gap : -1;
                exp_q.push_back(e);
            end
        end
    endtask

    // Monitor: handshake compare, stall stability, inter-packet gap length.
    logic [W-1:0] prev_data;
    logic [B-1:0] prev_keep;
    logic         prev_last;
    bit           stalled  = 1'b0;
    int           gap_pend = -1;
    int           gap_cnt  = 0;
    exp_t         got;

    always @(negedge aclk) begin
        if (areset) begin
            stalled  = 1'b0;
            gap_pend = -1;
        end else begin
            if (stalled) begin
                check("stall_valid", 64'(m_axis_tvalid), 64'd1);
                check("stall_data", 64'(m_axis_tdata), 64'(prev_data));
                check("stall_keep", 64'(m_axis_tkeep), 64'(prev_keep));
                if (!skip_last_stab) check("stall_last", 64'(m_axis_tlast), 64'(prev_last));
            end
            if (gap_pend >= 0) begin
                if (!m_axis_tvalid) begin
                    gap_cnt++;
                end else begin
                    check("gap_len", 64'(gap_cnt), 64'(gap_pend));
                    gap_pend = -1;
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL beat_unexpected: got data 0x%0h, expected no beat", m_axis_tdata);
                end else begin
                    got = exp_q.pop_front();
                    check("beat_data", 64'(m_axis_tdata), 64'(got.data));
                    check("beat_keep", 64'(m_axis_tkeep), 64'(got.keep));
                    check("beat_last", 64'(m_axis_tlast), 64'(got.last));
                    last_hs_cyc = cyc;
                    if (got.gap_after >= 0) begin
                        gap_pend = got.gap_after;
                        gap_cnt  = 0;
                    end
                end
            end
            stalled   = m_axis_tvalid && !m_axis_tready;
            prev_data = m_axis_tdata;
            prev_keep = m_axis_tkeep;
            prev_last = m_axis_tlast;
        end
    end

    task automatic start_cfg(input logic [W-1:0] s, input int len, input int cnt, input int gap);
        @(posedge aclk);
        #1;
        seed          = s;
        pkt_len_bytes = LW'(len);
        pkt_count     = CW'(cnt);
        gap_cycles    = 8'(gap);
        start         = 1'b1;
        @(posedge aclk);
        #1;
        start         = 1'b0;
        seed          = $urandom;
        pkt_len_bytes = LW'($urandom);
        pkt_count     = CW'($urandom);
        gap_cycles    = 8'($urandom);
    endtask

    task automatic wait_done(input int exp_sent);
        int t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (!done && t < 5000);
        if (!done) begin
            n_checks++;
            $display("FAIL done_timeout: got no done in %0d cycles, expected a pulse", t);
            return;
        end
        check("done_after_last", 64'(cyc), 64'(last_hs_cyc + 1));
        check("busy_at_done", 64'(busy), 64'd0);
        check("pkts_sent", 64'(pkts_sent), 64'(exp_sent));
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        @(negedge aclk);
        check("done_width", 64'(done), 64'd0);
        check("pkts_hold", 64'(pkts_sent), 64'(exp_sent));
    endtask

    task automatic run(input logic [W-1:0] s, input int len, input int cnt, input int gap, input bit poke);
        model_run(s, len, cnt, gap);
        start_cfg(s, len, cnt, gap);
        @(negedge aclk);
        if (len == 0 || cnt == 0) begin
            check("empty_done", 64'(done), 64'd1);
            check("empty_valid", 64'(m_axis_tvalid), 64'd0);
            check("empty_busy", 64'(busy), 64'd0);
            check("empty_sent", 64'(pkts_sent), 64'd0);
            @(negedge aclk);
            check("empty_done_width", 64'(done), 64'd0);
            check("empty_valid2", 64'(m_axis_tvalid), 64'd0);
            return;
        end
        check("first_valid", 64'(m_axis_tvalid), 64'd1);
        check("first_data", 64'(m_axis_tdata), 64'(s));
        check("start_busy", 64'(busy), 64'd1);
        check("start_clears_sent", 64'(pkts_sent), 64'd0);
        if (poke) begin
            repeat (3) @(posedge aclk);
            #1;
            if (busy) begin
                seed          = ~s;
                pkt_len_bytes = LW'(1);
                pkt_count     = CW'(1);
                start         = 1'b1;
                @(posedge aclk);
                #1;
                start         = 1'b0;
            end
        end
        wait_done(cnt);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected the run to end");
        $fatal(1);
    end

    initial begin : main
        logic [W-1:0] s;
        int           t;
        areset        = 1'b1;
        start         = 1'b0;
        pkt_len_bytes = '0;
        pkt_count     = '0;
        gap_cycles    = '0;
        seed          = '0;
`ifdef AXIS_GEN_ABORT_EN
        abort         = 1'b0;
`endif
        repeat (3) @(negedge aclk);
        check("rst_valid", 64'(m_axis_tvalid), 64'd0);
        check("rst_last", 64'(m_axis_tlast), 64'd0);
        check("rst_keep", 64'(m_axis_tkeep), 64'd0);
        check("rst_data", 64'(m_axis_tdata), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_sent", 64'(pkts_sent), 64'd0);
        #2 areset = 1'b0;

        ready_mode = 0;
        run(32'h10, 10, 2, 0, 1'b0);
        ready_mode = 1;
        run(32'h10, 10, 2, 0, 1'b0);
        ready_mode = 0;
        run($urandom, 8, 3, 3, 1'b0);
        ready_mode = 1;
        run($urandom, 8, 3, 3, 1'b0);
        ready_mode = 0;
        run($urandom, 0, 5, 2, 1'b0);
        run($urandom, 10, 0, 2, 1'b0);
        ready_mode = 1;
        run(32'hFFFF_FFFE, 13, 2, 1, 1'b0);
        run($urandom, 40, 3, 2, 1'b1);
        for (int i = 0; i < 6; i++) begin
            ready_mode = int'($urandom_range(0, 1));
            run($urandom, int'($urandom_range(1, 40)), int'($urandom_range(1, 3)),
                int'($urandom_range(0, 4)), 1'b0);
        end

        // Reset in the middle of packet 2 of 4.
        ready_mode = 0;
        s = $urandom;
        model_run(s, 16, 4, 1);
        start_cfg(s, 16, 4, 1);
        t = 0;
        while (pkts_sent != CW'(1) && t < 200) begin
            @(negedge aclk);
            t++;
        end
        repeat (3) @(negedge aclk);
        check("pre_reset_valid", 64'(m_axis_tvalid), 64'd1);
        #2 areset = 1'b1;
        #1;
        check("async_valid", 64'(m_axis_tvalid), 64'd0);
        check("async_last", 64'(m_axis_tlast), 64'd0);
        check("async_keep", 64'(m_axis_tkeep), 64'd0);
        check("async_busy", 64'(busy), 64'd0);
        check("async_sent", 64'(pkts_sent), 64'd0);
        exp_q.delete();
        @(negedge aclk);
        #2 areset = 1'b0;
        ready_mode = 1;
        run(s, 16, 4, 1, 1'b0);

`ifdef AXIS_GEN_ABORT_EN
        begin
            exp_t e;
            s = $urandom;
            for (int k = 0; k < 6; k++) begin
                e.data      = s + W'(k);
                e.keep      = '1;
                e.last      = (k == 3) || (k == 5);
                e.gap_after = (k == 3) ? 0 : -1;
                exp_q.push_back(e);
            end
            ready_mode = 0;
            start_cfg(s, 16, 4, 0);
            t = 0;
            while (m_axis_tdata != s + W'(5) && t < 100) begin
                @(posedge aclk);
                #1;
                t++;
            end
            man_ready      = 1'b0;
            ready_mode     = 2;
            abort          = 1'b1;
            skip_last_stab = 1'b1;
            @(posedge aclk);
            #1;
            abort     = 1'b0;
            man_ready = 1'b1;
            @(negedge aclk);
            check("abort_last", 64'(m_axis_tlast), 64'd1);
            check("abort_data", 64'(m_axis_tdata), 64'(s + W'(5)));
            check("abort_keep", 64'(m_axis_tkeep), 64'hF);
            wait_done(2);
            skip_last_stab = 1'b0;
            ready_mode     = 0;
        end
`endif

        repeat (3) @(negedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axis_packet_generator.md
Name: axis_packet_generator

Overview:
AXI-Stream master-side traffic source. It produces a run of framed packets that drive the slave port of the team's stream processing blocks.
Packet length, packet count, inter-packet gap and data seed are latched at start. Output is a deterministic incrementing data pattern with correct tkeep and tlast.
The block honours full backpressure and reports progress through busy, done and a sent-packet counter. It is used as the stimulus end of stream datapaths in bring-up and loopback builds.

Parameters:
TDATA_WIDTH, 32, stream data width in bits (32 or 64); BYTES = TDATA_WIDTH/8
LEN_WIDTH, 16, width of the packet byte-length field
CNT_WIDTH, 16, width of the packet-count field and the sent counter

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin a run; sampled only in IDLE
pkt_len_bytes  input  LEN_WIDTH  bytes per packet
pkt_count  input  CNT_WIDTH  packets per run
gap_cycles  input  8  idle cycles inserted between packets
seed  input  TDATA_WIDTH  data value of the first beat of the run
m_axis_tdata  output  TDATA_WIDTH  beat data
m_axis_tkeep  output  BYTES  byte enables
m_axis_tvalid  output  1  beat valid
m_axis_tlast  output  1  last beat of a packet
m_axis_tready  input  1  downstream ready
busy  output  1  run in progress
done  output  1  one-cycle pulse at end of run
pkts_sent  output  CNT_WIDTH  packets completed in the current or last run

Behaviour:
- Reset (async assert, output effect immediate): tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, done=0, pkts_sent=0, state=IDLE.
- States and transitions:
  - IDLE -> SEND on start when pkt_len_bytes!=0 and pkt_count!=0.
  - IDLE -> DONE on start when pkt_len_bytes==0 or pkt_count==0. No beats are emitted.
  - SEND -> GAP when tlast is accepted, more packets remain, and gap_cycles!=0.
  - SEND -> SEND when tlast is accepted, more packets remain, and gap_cycles==0.
  - GAP -> SEND after exactly gap_cycles cycles with tvalid=0.
  - SEND -> DONE when tlast of the final packet is accepted.
  - DONE -> IDLE after one cycle.
- On start acceptance: latch all config inputs, clear pkts_sent, set busy=1 on the next edge. Config inputs are don't-care after that.
- Latency: start high in cycle N gives tvalid=1 with the first beat in cycle N+1.
- start is ignored outside IDLE.
- Beats per packet = ceil(pkt_len_bytes/BYTES).
- Transfer occurs when tvalid && tready.
- Once tvalid is asserted, tdata, tkeep and tlast hold stable until the beat transfers. tvalid never depends combinationally on tready.
- Data pattern: beat k of the run (k counts from 0 across all packets) carries seed + k, modulo 2^TDATA_WIDTH.
- tkeep: all ones, except on a last beat where rem = pkt_len_bytes mod BYTES is nonzero; that beat carries the (rem) low-order bits set, e.g. rem=2 -> 4'b0011.
- Back-to-back packets (gap 0): the next packet's first beat is presented in the cycle after the tlast handshake, and tvalid stays high.
- pkts_sent increments on each tlast handshake and holds its value after done until the next accepted start.
- done is high for one cycle in DONE. busy falls in the same cycle done rises.
- areset mid-run: the run is abandoned, tvalid drops immediately, and the block returns to IDLE with reset values.

Optional Feature:
AXIS_GEN_ABORT_EN: adds input abort (1 bit).
- abort while in SEND: the current or next presented beat is forced to tlast=1 with tkeep all ones. An already-valid beat keeps its tdata.
- After that beat is accepted the block goes to DONE, and pkts_sent counts that truncated packet.
- abort while in GAP: go directly to DONE.
- abort in IDLE or DONE: ignored.
- Without the macro: no abort port, and the run always completes.

Test Plan:
- W=32, seed=0x10, len=10, count=2, gap=0, tready=1 -> 6 beats with data 0x10..0x15 and tvalid continuous. tlast on beats 3 and 6, tkeep 0xF,0xF,0x3 per packet. done one cycle after beat 6, pkts_sent=2.
- Same config with tready toggled pseudo-randomly -> identical beat sequence, and tdata/tkeep/tlast stable during every stall.
- len=8, count=3, gap=3 -> 2 beats per packet, tkeep 0xF on every beat. Exactly 3 tvalid-low cycles after each of the first two tlast handshakes. pkts_sent=3.
- start with len=0 (count=5) -> no tvalid, done pulse in cycle N+1, pkts_sent=0. Repeat with count=0 -> same result.
- areset asserted mid-packet 2 of 4 -> tvalid=0 without waiting for a clock edge. A new start then restarts from seed with pkts_sent cleared. start pulsed while busy has no effect.
- AXIS_GEN_ABORT_EN: len=16, count=4, abort on beat 2 of packet 2 with tready=0 -> the held beat's tlast rises, and after its acceptance done is pulsed with pkts_sent=2.
